// File: rtl/sd_data_pkg.sv
// Shared types and frame constants for the single-line SD data PHY.
package sd_data_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CRC_W  = 16;

    localparam logic [CRC_W-1:0] CRC16_POLY = 16'h1021;

    // Last bit index within the data and CRC sections of a frame
    localparam logic [5:0] DATA_LAST = 6'(DATA_W - 1);
    localparam logic [5:0] CRC_LAST  = 6'(CRC_W - 1);
    localparam logic [3:0] CRC_MSB   = 4'(CRC_W - 1);

    typedef enum logic [3:0] {
        IDLE,
        TX_START,
        TX_DATA,
        TX_CRC,
        TX_END,
        RX_WAIT,
        RX_DATA,
        RX_CRC,
        RX_END,
        DONE
    } state_t;

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC16-CCITT (poly 0x1021, init 0), one bit per enabled clock, MSB first.
module sd_crc16
    import sd_data_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic feedback;

    assign feedback = bit_in ^ crc[CRC_W-1];

    // LFSR update: clear has priority over shifting
    always_ff @(posedge clk) begin
        if (clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[CRC_W-2:0], 1'b0} ^ (feedback ? CRC16_POLY : '0);
        end
    end

endmodule

// File: rtl/sd_data_phy.sv
// DAT0 physical layer: serialises one word as start/data/CRC16/end, or waits
// for and deserialises a card frame, then reports Complete/Timeout/CRC_error.
module sd_data_phy
    import sd_data_pkg::*;
#(
    parameter int unsigned TO_W = 16
) (
    input  logic              SD_clock,
    input  logic              Reset,
    input  logic              Send,
    input  logic              WriteRead,
    input  logic              Idle,
    input  logic [DATA_W-1:0] Data_from_FIFO,
    input  logic              Timeout_enable,
    input  logic [TO_W-1:0]   Timeout_reg,
    input  logic              Data_pin_in,
    output logic              Data_pin_out,
    output logic              Data_oe,
    output logic              Serial_ready,
    output logic              Complete,
    output logic              Timeout,
    output logic              CRC_error,
    output logic [DATA_W-1:0] Data_to_FIFO,
    output logic              Write_FIFO
);

    state_t            state;
    logic [5:0]        bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [TO_W-1:0]   wait_cnt;
    logic [CRC_W-1:0]  rx_crc;
    logic              is_read;
    logic              frame_err;

    logic              crc_clear;
    logic              crc_enable;
    logic              crc_bit;
    logic [CRC_W-1:0]  crc;

    sd_crc16 u_crc (
        .clk    (SD_clock),
        .clear  (crc_clear),
        .enable (crc_enable),
        .bit_in (crc_bit),
        .crc    (crc)
    );

    // CRC feed: the bit leaving on TX or the bit arriving on RX, data section only
    always_comb begin
        crc_clear  = Reset || ((state == IDLE) && Send && !Idle);
        crc_enable = 1'b0;
        crc_bit    = 1'b0;
        if (!Reset && !Idle) begin
            if (state == TX_DATA) begin
                crc_enable = 1'b1;
                crc_bit    = shift_reg[DATA_W-1];
            end else if (state == RX_DATA) begin
                crc_enable = 1'b1;
                crc_bit    = Data_pin_in;
            end
        end
    end

    // Frame FSM with registered outputs; line outputs lag the state by one edge
    always_ff @(posedge SD_clock) begin
        if (Reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            wait_cnt     <= '0;
            rx_crc       <= '0;
            is_read      <= 1'b0;
            frame_err    <= 1'b0;
            Data_pin_out <= 1'b1;
            Data_oe      <= 1'b0;
            Serial_ready <= 1'b1;
            Complete     <= 1'b0;
            Timeout      <= 1'b0;
            CRC_error    <= 1'b0;
            Data_to_FIFO <= '0;
            Write_FIFO   <= 1'b0;
        end else begin
            Complete     <= 1'b0;
            Timeout      <= 1'b0;
            CRC_error    <= 1'b0;
            Write_FIFO   <= 1'b0;
            Serial_ready <= (state == IDLE);
            if (Idle) begin
                state        <= IDLE;
                Data_oe      <= 1'b0;
                Data_pin_out <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        Data_oe      <= 1'b0;
                        Data_pin_out <= 1'b1;
                        if (Send) begin
                            is_read   <= !WriteRead;
                            bit_cnt   <= '0;
                            frame_err <= 1'b0;
                            if (WriteRead) begin
                                shift_reg <= Data_from_FIFO;
                                state     <= TX_START;
                            end else begin
                                wait_cnt <= '0;
                                state    <= RX_WAIT;
                            end
                        end
                    end
                    TX_START: begin
                        Data_pin_out <= 1'b0;
                        Data_oe      <= 1'b1;
                        state        <= TX_DATA;
                    end
                    TX_DATA: begin
                        Data_pin_out <= shift_reg[DATA_W-1];
                        shift_reg    <= {shift_reg[DATA_W-2:0], 1'b0};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= TX_CRC;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    TX_CRC: begin
                        Data_pin_out <= crc[CRC_MSB - bit_cnt[3:0]];
                        if (bit_cnt == CRC_LAST) begin
                            bit_cnt <= '0;
                            state   <= TX_END;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    TX_END: begin
                        Data_pin_out <= 1'b1;
                        state        <= DONE;
                    end
                    RX_WAIT: begin
                        // A start bit takes precedence over a coincident timeout
                        if (!Data_pin_in) begin
                            bit_cnt <= '0;
                            state   <= RX_DATA;
                        end else begin
                            if (wait_cnt != '1) begin
                                wait_cnt <= wait_cnt + 1'b1;
                            end
                            if (Timeout_enable && (Timeout_reg != '0) &&
                                (wait_cnt == Timeout_reg)) begin
                                Timeout <= 1'b1;
                                state   <= IDLE;
                            end
                        end
                    end
                    RX_DATA: begin
                        shift_reg <= {shift_reg[DATA_W-2:0], Data_pin_in};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= RX_CRC;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    RX_CRC: begin
                        rx_crc <= {rx_crc[CRC_W-2:0], Data_pin_in};
                        if (bit_cnt == CRC_LAST) begin
                            bit_cnt <= '0;
                            state   <= RX_END;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    RX_END: begin
                        frame_err <= (rx_crc != crc) || !Data_pin_in;
                        state     <= DONE;
                    end
                    DONE: begin
                        Complete     <= 1'b1;
                        Data_oe      <= 1'b0;
                        Data_pin_out <= 1'b1;
                        if (is_read) begin
                            CRC_error <= frame_err;
                            if (!frame_err) begin
                                Data_to_FIFO <= shift_reg;
                                Write_FIFO   <= 1'b1;
                            end
                        end
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_data_phy.sv
// Scoreboard bench for sd_data_phy: stimulus pushes expected end-of-operation
// events and transmitted frames; a negedge monitor pops and compares them.
module tb_sd_data_phy;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Send = 1'b0;
    logic        WriteRead = 1'b0;
    logic        Idle = 1'b0;
    logic [31:0] Data_from_FIFO = '0;
    logic        Timeout_enable = 1'b0;
    logic [15:0] Timeout_reg = '0;
    logic        Data_pin_in = 1'b1;
    logic        Data_pin_out;
    logic        Data_oe;
    logic        Serial_ready;
    logic        Complete;
    logic        Timeout;
    logic        CRC_error;
    logic [31:0] Data_to_FIFO;
    logic        Write_FIFO;

    sd_data_phy #(.TO_W(16)) dut (
        .SD_clock       (clk),
        .Reset          (Reset),
        .Send           (Send),
        .WriteRead      (WriteRead),
        .Idle           (Idle),
        .Data_from_FIFO (Data_from_FIFO),
        .Timeout_enable (Timeout_enable),
        .Timeout_reg    (Timeout_reg),
        .Data_pin_in    (Data_pin_in),
        .Data_pin_out   (Data_pin_out),
        .Data_oe        (Data_oe),
        .Serial_ready   (Serial_ready),
        .Complete       (Complete),
        .Timeout        (Timeout),
        .CRC_error      (CRC_error),
        .Data_to_FIFO   (Data_to_FIFO),
        .Write_FIFO     (Write_FIFO)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        bit          is_timeout;
        bit          crc_err;
        bit          wr_fifo;
        logic [31:0] data;
        int unsigned at;
    } ev_t;

    typedef struct {
        logic [49:0] bits;
        int unsigned len;
    } fr_t;

    ev_t ev_q[$];
    fr_t fr_q[$];
    logic [31:0] last_good = '0;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // CRC as the remainder of (message * x^16) divided by x^16 + x^12 + x^5 + 1
    function automatic logic [15:0] ref_crc(input logic [31:0] d);
        logic [47:0] m;
        m = {d, 16'h0000};
        for (int i = 47; i >= 16; i--) begin
            if (m[i]) m[i -: 17] = m[i -: 17] ^ 17'h1_1021;
        end
        return m[15:0];
    endfunction

    function automatic logic [49:0] make_frame(input logic [31:0] d);
        return {1'b0, d, ref_crc(d), 1'b1};
    endfunction

    // Monitor: compares end events and captured DAT frames against the queues
    ev_t         mon_e;
    fr_t         mon_f;
    logic [49:0] got_bits = '0;
    int unsigned got_len = 0;
    bit          rdy_pend = 1'b0;

    always @(negedge clk) begin
        if (rdy_pend) begin
            check("ready_after_end", Serial_ready, 1);
            rdy_pend = 1'b0;
        end
        if (Write_FIFO && !Complete) begin
            compared++;
            mismatched++;
            $display("FAIL write_fifo_alone: Write_FIFO=1 Complete=0, required Complete=1 (cycle %0d)", cyc);
        end
        if (Complete || Timeout) begin
            if (ev_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_end: Complete=%b Timeout=%b, required none (cycle %0d)", Complete, Timeout, cyc);
            end else begin
                mon_e = ev_q.pop_front();
                check("timeout_flag", Timeout, mon_e.is_timeout);
                check("complete_flag", Complete, !mon_e.is_timeout);
                check("end_cycle", cyc, mon_e.at);
                check("crc_error", CRC_error, mon_e.crc_err);
                check("write_fifo", Write_FIFO, mon_e.wr_fifo);
                check("data_to_fifo", Data_to_FIFO, mon_e.data);
                check("oe_at_end", Data_oe, 0);
                check("ready_at_end", Serial_ready, 0);
                rdy_pend = 1'b1;
            end
        end
        if (Data_oe) begin
            if (got_len < 50) got_bits[49 - got_len] = Data_pin_out;
            got_len++;
        end else if (got_len != 0) begin
            if (fr_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_frame: %0d bits driven, required none", got_len);
            end else begin
                mon_f = fr_q.pop_front();
                check("tx_frame_len", got_len, mon_f.len);
                check("tx_frame_bits", got_bits, mon_f.bits);
            end
            got_len  = 0;
            got_bits = '0;
        end
    end

    task automatic drain();
        int unsigned n = 0;
        @(negedge clk); #1;
        while ((ev_q.size() != 0 || fr_q.size() != 0 || Serial_ready !== 1'b1) && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        check("pending_after_op", ev_q.size() + fr_q.size(), 0);
        check("ready_after_op", Serial_ready, 1);
        ev_q.delete();
        fr_q.delete();
    endtask

    task automatic do_write(input logic [31:0] d);
        ev_t e;
        fr_t f;
        f.bits = make_frame(d);
        f.len  = 50;
        fr_q.push_back(f);
        e.is_timeout = 1'b0; e.crc_err = 1'b0; e.wr_fifo = 1'b0;
        e.data = last_good; e.at = cyc + 52;
        ev_q.push_back(e);
        Send = 1'b1; WriteRead = 1'b1; Data_from_FIFO = d;
        @(negedge clk); #1;
        Send = 1'b0;
        Data_from_FIFO = $urandom;
        drain();
    endtask

    task automatic do_read(input logic [49:0] fr, input int unsigned pre, input logic [15:0] to_reg);
        ev_t e;
        bit  err;
        err = (fr[16:1] != ref_crc(fr[48:17])) || (fr[0] == 1'b0);
        Timeout_enable = 1'b1; Timeout_reg = to_reg;
        Send = 1'b1; WriteRead = 1'b0; Data_pin_in = 1'b1;
        @(negedge clk); #1;
        Send = 1'b0;
        repeat (pre) begin @(negedge clk); #1; end
        e.is_timeout = 1'b0; e.crc_err = err; e.wr_fifo = !err;
        e.data = err ? last_good : fr[48:17];
        e.at = cyc + 51;
        ev_q.push_back(e);
        if (!err) last_good = fr[48:17];
        for (int b = 49; b >= 0; b--) begin
            Data_pin_in = fr[b];
            check("read_oe_low", Data_oe, 0);
            @(negedge clk); #1;
        end
        Data_pin_in = 1'b1;
        drain();
    endtask

    task automatic do_timeout(input logic [15:0] to_reg);
        ev_t e;
        Timeout_enable = 1'b1; Timeout_reg = to_reg;
        e.is_timeout = 1'b1; e.crc_err = 1'b0; e.wr_fifo = 1'b0;
        e.data = last_good; e.at = cyc + 1 + to_reg + 1;
        ev_q.push_back(e);
        Send = 1'b1; WriteRead = 1'b0; Data_pin_in = 1'b1;
        @(negedge clk); #1;
        Send = 1'b0;
        drain();
    endtask

    // Idle is sampled at the j-th edge after Send, so j-1 bits reach the line
    task automatic do_write_abort(input logic [31:0] d, input int unsigned j);
        fr_t f;
        logic [49:0] mask;
        mask   = '1;
        mask   = mask << (50 - (j - 1));
        f.bits = make_frame(d) & mask;
        f.len  = j - 1;
        fr_q.push_back(f);
        Send = 1'b1; WriteRead = 1'b1; Data_from_FIFO = d;
        @(negedge clk); #1;
        Send = 1'b0;
        repeat (j - 1) begin @(negedge clk); #1; end
        Idle = 1'b1;
        @(negedge clk); #1;
        Idle = 1'b0;
        check("abort_oe", Data_oe, 0);
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [49:0] fr;
        logic [31:0] d;
        int unsigned pre;
        int unsigned kind;

        repeat (2) @(negedge clk);
        #1;
        check("rst_pin_out", Data_pin_out, 1);
        check("rst_oe", Data_oe, 0);
        check("rst_ready", Serial_ready, 1);
        check("rst_complete", Complete, 0);
        check("rst_timeout", Timeout, 0);
        check("rst_crc_error", CRC_error, 0);
        check("rst_write_fifo", Write_FIFO, 0);
        check("rst_data_to_fifo", Data_to_FIFO, 0);
        Reset = 1'b0;
        @(negedge clk); #1;

        do_write(32'h0000_04E2);
        do_write(32'h0000_0000);
        fr = make_frame(32'h0000_04E2);
        do_read(fr, 8, 16'd500);
        fr[17 + 5] = ~fr[17 + 5];
        do_read(fr, 8, 16'd500);
        fr = make_frame(32'h0000_04E2);
        fr[0] = 1'b0;
        do_read(fr, 8, 16'd500);
        do_read(make_frame(32'hCAFE_F00D), 12, 16'd12);

        do_timeout(16'd70);
        do_timeout(16'd1);

        Timeout_enable = 1'b1; Timeout_reg = 16'd0;
        Send = 1'b1; WriteRead = 1'b0; Data_pin_in = 1'b1;
        @(negedge clk); #1;
        Send = 1'b0;
        repeat (1000) begin @(negedge clk); #1; end
        check("no_timeout_still_waiting", Serial_ready, 0);
        Idle = 1'b1;
        @(negedge clk); #1;
        Idle = 1'b0;
        drain();

        Send = 1'b1; WriteRead = 1'b1; Idle = 1'b1; Data_from_FIFO = 32'h1234_5678;
        @(negedge clk); #1;
        Send = 1'b0; Idle = 1'b0;
        @(negedge clk); #1;
        check("send_with_idle_ready", Serial_ready, 1);
        check("send_with_idle_oe", Data_oe, 0);
        drain();

        do_write_abort(32'hA5A5_3C3C, 24);
        do_write(32'h0BAD_BEEF);

        fr = make_frame(32'h7654_3210);
        Timeout_enable = 1'b0;
        Send = 1'b1; WriteRead = 1'b0; Data_pin_in = 1'b1;
        @(negedge clk); #1;
        Send = 1'b0;
        repeat (3) begin @(negedge clk); #1; end
        for (int b = 49; b >= 39; b--) begin
            Data_pin_in = fr[b];
            @(negedge clk); #1;
        end
        Reset = 1'b1;
        @(negedge clk); #1;
        Reset = 1'b0;
        Data_pin_in = 1'b1;
        last_good = '0;
        check("midread_rst_ready", Serial_ready, 1);
        check("midread_rst_oe", Data_oe, 0);
        check("midread_rst_data", Data_to_FIFO, 0);
        check("midread_rst_crc_error", CRC_error, 0);
        drain();
        do_read(make_frame(32'h0000_04E2), 8, 16'd500);

        for (int n = 0; n < 20; n++) begin
            d    = $urandom;
            kind = $urandom_range(0, 3);
            pre  = $urandom_range(0, 10);
            if (kind == 0) begin
                do_write(d);
            end else begin
                fr = make_frame(d);
                if (kind == 2) fr[$urandom_range(1, 48)] ^= 1'b1;
                if (kind == 3 && $urandom_range(0, 1) == 1) fr[0] = 1'b0;
                do_read(fr, pre, 16'(pre + $urandom_range(0, 3)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
